// File: rtl/wired_tl_a_arbiter.sv
// Two-link TileLink A/D arbiter: per-message A grant with burst lock, link-index source tagging,
// D routing by source MSB and a per-link outstanding limit. Define WIRED_TL_ARB_RR_EN for round-robin.
module wired_tl_a_arbiter #(
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 32,
  parameter int SOURCE_WIDTH    = 2,
  parameter int MAX_SIZE        = 6,
  parameter int MAX_OUTSTANDING = 2,
  parameter int SINK_WIDTH      = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [1:0]                             req_a_valid_i,
  output logic [1:0]                             req_a_ready_o,
  input  logic [1:0][2:0]                        req_a_opcode_i,
  input  logic [1:0][2:0]                        req_a_size_i,
  input  logic [1:0][SOURCE_WIDTH-2:0]           req_a_source_i,
  input  logic [1:0][ADDR_WIDTH-1:0]             req_a_address_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]           req_a_mask_i,
  input  logic [1:0][DATA_WIDTH-1:0]             req_a_data_i,
  output logic                                   dev_a_valid_o,
  input  logic                                   dev_a_ready_i,
  output logic [2:0]                             dev_a_opcode_o,
  output logic [2:0]                             dev_a_size_o,
  output logic [SOURCE_WIDTH-1:0]                dev_a_source_o,
  output logic [ADDR_WIDTH-1:0]                  dev_a_address_o,
  output logic [DATA_WIDTH/8-1:0]                dev_a_mask_o,
  output logic [DATA_WIDTH-1:0]                  dev_a_data_o,
  input  logic                                   dev_d_valid_i,
  output logic                                   dev_d_ready_o,
  input  logic [2:0]                             dev_d_opcode_i,
  input  logic [2:0]                             dev_d_size_i,
  input  logic [SOURCE_WIDTH-1:0]                dev_d_source_i,
  input  logic [SINK_WIDTH-1:0]                  dev_d_sink_i,
  input  logic [DATA_WIDTH-1:0]                  dev_d_data_i,
  output logic [1:0]                             req_d_valid_o,
  input  logic [1:0]                             req_d_ready_i,
  output logic [2:0]                             req_d_opcode_o,
  output logic [2:0]                             req_d_size_o,
  output logic [SOURCE_WIDTH-2:0]                req_d_source_o,
  output logic [SINK_WIDTH-1:0]                  req_d_sink_o,
  output logic [DATA_WIDTH-1:0]                  req_d_data_o
);

  localparam int MAX_BEATS = (MAX_SIZE > 4) ? (1 << (MAX_SIZE - 4)) : 1;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);
  localparam logic [1:0] OUT_LIMIT = 2'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_next;
  logic               grant, grant_next;
  logic               sel, winner;
  logic               a_fire, a_first, a_last, a_data;
  logic [CNT_W-1:0]   a_beats;
  logic [1:0]         eligible;
  logic [1:0][1:0]    outstanding;
  logic [1:0]         out_inc, out_dec;
  logic [CNT_W-1:0]   d_beat_cnt, d_beat_cnt_next;
  logic [CNT_W-1:0]   d_beats;
  logic               d_link, d_fire, d_last, d_data;

  function automatic logic [CNT_W-1:0] beats_of(input logic [2:0] size);
    if (size > 3'd4) return CNT_W'(1) << (size - 3'd4);
    return CNT_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++)
      eligible[i] = req_a_valid_i[i] && (outstanding[i] < OUT_LIMIT);
  end

`ifdef WIRED_TL_ARB_RR_EN
  logic rr_ptr;

  assign winner = eligible[rr_ptr] ? rr_ptr : ~rr_ptr;

  // Preference flips to the other link whenever a message finishes its last A beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ptr <= 1'b0;
    else if (a_last) rr_ptr <= ~sel;
  end
`else
  assign winner = ~eligible[0];
`endif

  assign a_data  = (req_a_opcode_i[winner] == 3'd0) || (req_a_opcode_i[winner] == 3'd1);
  assign a_beats = beats_of(req_a_size_i[winner]);

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    grant_next    = grant;
    sel           = grant;
    dev_a_valid_o = 1'b0;
    req_a_ready_o = 2'b00;
    a_fire        = 1'b0;
    a_first       = 1'b0;
    a_last        = 1'b0;
    case (state)
      IDLE: begin
        sel                   = winner;
        dev_a_valid_o         = |eligible;
        req_a_ready_o[winner] = dev_a_ready_i && (|eligible);
        a_fire                = dev_a_valid_o && dev_a_ready_i;
        if (a_fire) begin
          a_first = 1'b1;
          if (a_data && (a_beats > CNT_W'(1))) begin
            state_next    = BURST;
            grant_next    = winner;
            beat_cnt_next = a_beats - CNT_W'(1);
          end else begin
            a_last = 1'b1;
          end
        end
      end
      BURST: begin
        // Grant stays locked; the other link sees no ready until the last beat.
        dev_a_valid_o        = req_a_valid_i[grant];
        req_a_ready_o[grant] = dev_a_ready_i;
        a_fire               = dev_a_valid_o && dev_a_ready_i;
        if (a_fire) begin
          beat_cnt_next = beat_cnt - CNT_W'(1);
          if (beat_cnt == CNT_W'(1)) begin
            state_next = IDLE;
            a_last     = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      grant    <= 1'b0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
      grant    <= grant_next;
    end
  end

  assign dev_a_opcode_o  = req_a_opcode_i[sel];
  assign dev_a_size_o    = req_a_size_i[sel];
  assign dev_a_source_o  = {sel, req_a_source_i[sel]};
  assign dev_a_address_o = req_a_address_i[sel];
  assign dev_a_mask_o    = req_a_mask_i[sel];
  assign dev_a_data_o    = req_a_data_i[sel];

  assign d_link        = dev_d_source_i[SOURCE_WIDTH-1];
  assign req_d_valid_o = {dev_d_valid_i && d_link, dev_d_valid_i && !d_link};
  assign dev_d_ready_o = req_d_ready_i[d_link];
  assign d_fire        = dev_d_valid_i && dev_d_ready_o;
  assign d_data        = (dev_d_opcode_i == 3'd1) || (dev_d_opcode_i == 3'd5);
  assign d_beats       = beats_of(dev_d_size_i);

  assign req_d_opcode_o = dev_d_opcode_i;
  assign req_d_size_o   = dev_d_size_i;
  assign req_d_source_o = dev_d_source_i[SOURCE_WIDTH-2:0];
  assign req_d_sink_o   = dev_d_sink_i;
  assign req_d_data_o   = dev_d_data_i;

  // A zero D beat count means the next D beat starts a new response.
  always_comb begin
    d_beat_cnt_next = d_beat_cnt;
    d_last          = 1'b0;
    if (d_fire) begin
      if (d_beat_cnt == '0) begin
        if (d_data && (d_beats > CNT_W'(1))) d_beat_cnt_next = d_beats - CNT_W'(1);
        else                                 d_last = 1'b1;
      end else begin
        d_beat_cnt_next = d_beat_cnt - CNT_W'(1);
        d_last          = (d_beat_cnt == CNT_W'(1));
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      out_inc[i] = a_first && (sel == 1'(i));
      out_dec[i] = d_last && (d_link == 1'(i)) && (outstanding[i] != 2'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_beat_cnt  <= '0;
      outstanding <= '0;
    end else begin
      d_beat_cnt <= d_beat_cnt_next;
      for (int i = 0; i < 2; i++) begin
        if (out_inc[i] && !out_dec[i])      outstanding[i] <= outstanding[i] + 2'd1;
        else if (out_dec[i] && !out_inc[i]) outstanding[i] <= outstanding[i] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_wired_tl_a_arbiter.sv
// Directed vector bench for wired_tl_a_arbiter; one table of per-cycle vectors plus a reset-mid-burst sequence.
// Arbitration expectations follow WIRED_TL_ARB_RR_EN when it is defined.
module tb_wired_tl_a_arbiter;

  localparam logic [2:0] GET = 3'd4, PUTF = 3'd0, PUTP = 3'd1, ACK = 3'd0, ACKD = 3'd1;
  localparam logic [31:0] ADDR0 = 32'hA000_0040, ADDR1 = 32'hB000_0080;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        a_valid;
  logic [1:0]        a_ready;
  logic [1:0][2:0]   a_opcode, a_size;
  logic [1:0][0:0]   a_source;
  logic [1:0][31:0]  a_address;
  logic [1:0][15:0]  a_mask;
  logic [1:0][127:0] a_data;
  logic              dev_a_valid, dev_a_ready;
  logic [2:0]        dev_a_opcode, dev_a_size;
  logic [1:0]        dev_a_source;
  logic [31:0]       dev_a_address;
  logic [15:0]       dev_a_mask;
  logic [127:0]      dev_a_data;
  logic              dev_d_valid, dev_d_ready;
  logic [2:0]        dev_d_opcode, dev_d_size;
  logic [1:0]        dev_d_source;
  logic [1:0]        dev_d_sink;
  logic [127:0]      dev_d_data;
  logic [1:0]        d_valid, d_ready;
  logic [2:0]        d_opcode, d_size;
  logic [0:0]        d_source;
  logic [1:0]        d_sink;
  logic [127:0]      d_data;

  int total = 0;
  int bad   = 0;

  wired_tl_a_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a_valid_i(a_valid), .req_a_ready_o(a_ready),
    .req_a_opcode_i(a_opcode), .req_a_size_i(a_size), .req_a_source_i(a_source),
    .req_a_address_i(a_address), .req_a_mask_i(a_mask), .req_a_data_i(a_data),
    .dev_a_valid_o(dev_a_valid), .dev_a_ready_i(dev_a_ready),
    .dev_a_opcode_o(dev_a_opcode), .dev_a_size_o(dev_a_size), .dev_a_source_o(dev_a_source),
    .dev_a_address_o(dev_a_address), .dev_a_mask_o(dev_a_mask), .dev_a_data_o(dev_a_data),
    .dev_d_valid_i(dev_d_valid), .dev_d_ready_o(dev_d_ready),
    .dev_d_opcode_i(dev_d_opcode), .dev_d_size_i(dev_d_size), .dev_d_source_i(dev_d_source),
    .dev_d_sink_i(dev_d_sink), .dev_d_data_i(dev_d_data),
    .req_d_valid_o(d_valid), .req_d_ready_i(d_ready),
    .req_d_opcode_o(d_opcode), .req_d_size_o(d_size), .req_d_source_o(d_source),
    .req_d_sink_o(d_sink), .req_d_data_o(d_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] av;
    logic [2:0] op0, sz0, op1, sz1;
    logic       ar;
    logic       dv;
    logic [2:0] dop, dsz;
    logic [1:0] dsrc, drdy;
    logic [1:0] exp_a_ready;
    logic       exp_dev_a_valid;
    logic [1:0] exp_source;
    logic [1:0] exp_d_valid;
    logic       exp_dev_d_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] av, input logic [2:0] op0, input logic [2:0] sz0,
                              input logic [2:0] op1, input logic [2:0] sz1, input logic ar,
                              input logic [1:0] ear, input logic edv, input logic [1:0] esrc);
    vec_t v;
    v = '{default: '0};
    v.av = av; v.op0 = op0; v.sz0 = sz0; v.op1 = op1; v.sz1 = sz1; v.ar = ar;
    v.exp_a_ready = ear; v.exp_dev_a_valid = edv; v.exp_source = esrc;
    return v;
  endfunction

  function automatic vec_t withD(input vec_t base, input logic [2:0] dop, input logic [2:0] dsz,
                                 input logic [1:0] dsrc, input logic [1:0] drdy,
                                 input logic [1:0] edv, input logic eddr);
    vec_t v;
    v = base;
    v.dv = 1'b1; v.dop = dop; v.dsz = dsz; v.dsrc = dsrc; v.drdy = drdy;
    v.exp_d_valid = edv; v.exp_dev_d_ready = eddr;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    a_valid      = v.av;
    a_opcode[0]  = v.op0; a_size[0] = v.sz0;
    a_opcode[1]  = v.op1; a_size[1] = v.sz1;
    dev_a_ready  = v.ar;
    dev_d_valid  = v.dv;
    dev_d_opcode = v.dop;
    dev_d_size   = v.dsz;
    dev_d_source = v.dsrc;
    d_ready      = v.drdy;
  endtask

  task automatic checkVal(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL v%0d %s: got %0h expected %0h", id, what, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int id);
    #1;
    checkVal(id, "a_ready", 32'(a_ready), 32'(v.exp_a_ready));
    checkVal(id, "dev_a_valid", 32'(dev_a_valid), 32'(v.exp_dev_a_valid));
    if (v.exp_dev_a_valid) begin
      checkVal(id, "dev_a_source", 32'(dev_a_source), 32'(v.exp_source));
      checkVal(id, "dev_a_address", dev_a_address, v.exp_source[1] ? ADDR1 : ADDR0);
      checkVal(id, "dev_a_opcode", 32'(dev_a_opcode), 32'(v.exp_source[1] ? v.op1 : v.op0));
    end
    checkVal(id, "req_d_valid", 32'(d_valid), 32'(v.exp_d_valid));
    checkVal(id, "dev_d_ready", 32'(dev_d_ready), 32'(v.exp_dev_d_ready));
    if (v.dv) begin
      checkVal(id, "req_d_source", 32'(d_source), 32'(v.dsrc[0]));
      checkVal(id, "req_d_opcode", 32'(d_opcode), 32'(v.dop));
    end
  endtask

  task automatic step(input vec_t v, input int id);
    @(negedge clk);
    applyStimulus(v);
    checkOutput(v, id);
  endtask

  initial begin
    vec_t idle, g0ok, g0st, g1ok, g1st, both, v;

    rst = 1'b1;
    a_source[0] = 1'b0; a_source[1] = 1'b1;
    a_address[0] = ADDR0; a_address[1] = ADDR1;
    a_mask[0] = 16'h00FF; a_mask[1] = 16'hFF00;
    a_data[0] = {4{32'h1111_0000}}; a_data[1] = {4{32'h2222_0000}};
    dev_d_sink = 2'd1; dev_d_data = {4{32'hD0D0_D0D0}};

    idle = mk(2'b00, GET, 3'd4, GET, 3'd4, 1'b1, 2'b00, 1'b0, 2'b00);
    g0ok = mk(2'b01, GET, 3'd4, GET, 3'd4, 1'b1, 2'b01, 1'b1, 2'b00);
    g0st = mk(2'b01, GET, 3'd4, GET, 3'd4, 1'b1, 2'b00, 1'b0, 2'b00);
    g1ok = mk(2'b10, GET, 3'd4, GET, 3'd4, 1'b1, 2'b10, 1'b1, 2'b11);
    g1st = mk(2'b10, GET, 3'd4, GET, 3'd4, 1'b1, 2'b00, 1'b0, 2'b00);
    both = mk(2'b11, GET, 3'd4, GET, 3'd4, 1'b1, 2'b00, 1'b0, 2'b00);

    // Link 0 outstanding limit, release by AccessAckData, no wrap below zero.
    vecs.push_back(idle);
    vecs.push_back(g0ok); vecs.push_back(g0ok); vecs.push_back(g0st);
    vecs.push_back(withD(g0st, ACKD, 3'd4, 2'b00, 2'b00, 2'b01, 1'b0));
    vecs.push_back(withD(g0st, ACKD, 3'd4, 2'b00, 2'b01, 2'b01, 1'b1));
    vecs.push_back(g0ok);
    for (int i = 0; i < 3; i++) vecs.push_back(withD(idle, ACK, 3'd4, 2'b00, 2'b01, 2'b01, 1'b1));
    vecs.push_back(g0ok); vecs.push_back(g0ok); vecs.push_back(g0st);
    for (int i = 0; i < 2; i++) vecs.push_back(withD(idle, ACK, 3'd4, 2'b00, 2'b01, 2'b01, 1'b1));
    // Link 1 at limit; 4-beat AccessAckData with toggling ready frees a slot only after beat 4.
    vecs.push_back(g1ok); vecs.push_back(g1ok); vecs.push_back(g1st);
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(withD(g1st, ACKD, 3'd6, 2'b10, 2'b10, 2'b10, 1'b1));
      vecs.push_back(withD(g1st, ACKD, 3'd6, 2'b10, 2'b01, 2'b10, 1'b0));
    end
    vecs.push_back(withD(g1st, ACKD, 3'd6, 2'b10, 2'b10, 2'b10, 1'b1));
    vecs.push_back(g1ok);
    for (int i = 0; i < 2; i++) vecs.push_back(withD(idle, ACK, 3'd4, 2'b10, 2'b10, 2'b10, 1'b1));
    // Link 1 4-beat PutFull locks out link 0, including a downstream stall cycle.
    vecs.push_back(mk(2'b10, GET, 3'd4, PUTF, 3'd6, 1'b1, 2'b10, 1'b1, 2'b11));
    vecs.push_back(mk(2'b11, GET, 3'd4, PUTF, 3'd6, 1'b1, 2'b10, 1'b1, 2'b11));
    vecs.push_back(mk(2'b11, GET, 3'd4, PUTF, 3'd6, 1'b0, 2'b00, 1'b1, 2'b11));
    vecs.push_back(mk(2'b11, GET, 3'd4, PUTF, 3'd6, 1'b1, 2'b10, 1'b1, 2'b11));
    vecs.push_back(mk(2'b11, GET, 3'd4, PUTF, 3'd6, 1'b1, 2'b10, 1'b1, 2'b11));
    vecs.push_back(mk(2'b11, GET, 3'd4, GET, 3'd4, 1'b1, 2'b01, 1'b1, 2'b00));
    vecs.push_back(withD(idle, ACK, 3'd4, 2'b10, 2'b10, 2'b10, 1'b1));
    vecs.push_back(withD(idle, ACK, 3'd4, 2'b00, 2'b01, 2'b01, 1'b1));
    // Large Get and small PutPartial are single-beat messages.
    vecs.push_back(mk(2'b01, GET, 3'd6, GET, 3'd4, 1'b1, 2'b01, 1'b1, 2'b00));
    vecs.push_back(g1ok);
    vecs.push_back(mk(2'b10, GET, 3'd4, PUTP, 3'd4, 1'b1, 2'b10, 1'b1, 2'b11));
    vecs.push_back(g0ok);
    for (int i = 0; i < 2; i++) vecs.push_back(withD(idle, ACKD, 3'd4, 2'b00, 2'b01, 2'b01, 1'b1));
    for (int i = 0; i < 2; i++) vecs.push_back(withD(idle, ACKD, 3'd4, 2'b10, 2'b10, 2'b10, 1'b1));
    // Both links continuously valid; preference was left on link 1 by the last message.
`ifdef WIRED_TL_ARB_RR_EN
    v = both; v.exp_a_ready = 2'b10; v.exp_dev_a_valid = 1'b1; v.exp_source = 2'b11; vecs.push_back(v);
    v = both; v.exp_a_ready = 2'b01; v.exp_dev_a_valid = 1'b1; v.exp_source = 2'b00; vecs.push_back(v);
    v = both; v.exp_a_ready = 2'b10; v.exp_dev_a_valid = 1'b1; v.exp_source = 2'b11; vecs.push_back(v);
    v = both; v.exp_a_ready = 2'b01; v.exp_dev_a_valid = 1'b1; v.exp_source = 2'b00; vecs.push_back(v);
`else
    v = both; v.exp_a_ready = 2'b01; v.exp_dev_a_valid = 1'b1; v.exp_source = 2'b00; vecs.push_back(v);
    vecs.push_back(v);
    v = both; v.exp_a_ready = 2'b10; v.exp_dev_a_valid = 1'b1; v.exp_source = 2'b11; vecs.push_back(v);
    vecs.push_back(v);
`endif
    vecs.push_back(both);
    for (int i = 0; i < 2; i++) vecs.push_back(withD(idle, ACK, 3'd4, 2'b00, 2'b01, 2'b01, 1'b1));
    for (int i = 0; i < 2; i++) vecs.push_back(withD(idle, ACK, 3'd4, 2'b10, 2'b10, 2'b10, 1'b1));

    applyStimulus(idle);
    @(negedge clk);
    @(negedge clk);
    checkOutput(idle, -1);
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i], i);

    // Reset lands during beat 2 of a link-1 PutFull burst.
    v = mk(2'b10, GET, 3'd4, PUTF, 3'd6, 1'b1, 2'b10, 1'b1, 2'b11);
    step(v, 100);
    step(v, 101);
    rst = 1'b1;
    step(idle, 102);
    rst = 1'b0;
    step(mk(2'b11, GET, 3'd4, GET, 3'd4, 1'b1, 2'b01, 1'b1, 2'b00), 103);
    step(g1ok, 104);
    step(g1ok, 105);
    step(g1st, 106);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
